// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential radix-2 restoring divider.
// The DIV_FAST_PATH_EN macro (see seq_divider.sv) does not affect this file.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } div_state_t;

    localparam int DIV_DEFAULT_WIDTH = 32;

    // Edges from the accept edge to the edge that raises completed.
    function automatic int div_latency(input int width);
        return width + 1;
    endfunction

    localparam int DIV_LATENCY = div_latency(DIV_DEFAULT_WIDTH);

endpackage

// File: rtl/seq_divider_if.sv
// Request/response handshake between the ALU (master) and seq_divider (slave).
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             enable;
    logic             is_signed;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] t;
    logic             completed;
    logic             busy;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;

    modport master (
        output enable, is_signed, s, t,
        input  completed, busy, q, r
    );

    modport slave (
        input  enable, is_signed, s, t,
        output completed, busy, q, r
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One combinational restoring-division iteration: shift {rem, quot} left and
// keep the trial difference when the divisor fits.
module seq_divider_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quot_next
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           fits;

    assign shifted = {rem[WIDTH-1:0], quot[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};
    // A bit shifted out of the top means the trial value exceeds any divisor.
    assign fits    = rem[WIDTH] | ~diff[WIDTH];

    always_comb begin
        rem_next  = fits ? diff : shifted;
        quot_next = {quot[WIDTH-2:0], fits};
    end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider with RISC-V corner-case results.
// Define DIV_FAST_PATH_EN to finish divide-by-zero, signed overflow and t==1 in one edge.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rstn,
    seq_divider_if.slave bus
);
    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             signed_q, signed_d;
    logic             s_neg_q, s_neg_d;
    logic             t_neg_q, t_neg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_res_q, q_res_d;
    logic [WIDTH-1:0] r_res_q, r_res_d;

    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quot_step;
    logic             s_neg_in, t_neg_in;
    logic [WIDTH-1:0] s_mag, t_mag;
    logic [WIDTH-1:0] q_fix, r_fix;

    seq_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (dvsr_q),
        .rem_next  (rem_step),
        .quot_next (quot_step)
    );

    // The most negative value's magnitude fits as an unsigned WIDTH-bit number.
    assign s_neg_in = bus.is_signed & bus.s[WIDTH-1];
    assign t_neg_in = bus.is_signed & bus.t[WIDTH-1];
    assign s_mag    = s_neg_in ? -bus.s : bus.s;
    assign t_mag    = t_neg_in ? -bus.t : bus.t;

    assign q_fix = (signed_q & (s_neg_q ^ t_neg_q)) ? -quot_q : quot_q;
    assign r_fix = s_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

`ifdef DIV_FAST_PATH_EN
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic             fast_zero, fast_hit;
    logic [WIDTH-1:0] fast_q, fast_r;

    // Overflow and t==1 both return the dividend unchanged with a zero remainder.
    assign fast_zero = (bus.t == '0);
    assign fast_hit  = fast_zero || (bus.t == ONE) ||
                       (bus.is_signed && bus.s == MOST_NEG && bus.t == '1);
    assign fast_q    = fast_zero ? '1 : bus.s;
    assign fast_r    = fast_zero ? bus.s : '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvsr_d   = dvsr_q;
        signed_d = signed_q;
        s_neg_d  = s_neg_q;
        t_neg_d  = t_neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        q_res_d  = q_res_q;
        r_res_d  = r_res_q;

        case (state_q)
            IDLE: begin
                if (bus.enable) begin
                    signed_d = bus.is_signed;
                    s_neg_d  = s_neg_in;
                    t_neg_d  = t_neg_in;
                    quot_d   = s_mag;
                    dvsr_d   = t_mag;
                    rem_d    = '0;
                    cnt_d    = '0;
`ifdef DIV_FAST_PATH_EN
                    if (fast_hit) begin
                        q_res_d = fast_q;
                        r_res_d = fast_r;
                        done_d  = 1'b1;
                    end else begin
                        busy_d  = 1'b1;
                        state_d = ITER;
                    end
`else
                    busy_d  = 1'b1;
                    state_d = ITER;
`endif
                end
            end
            ITER: begin
                rem_d  = rem_step;
                quot_d = quot_step;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Divide by zero leaves rem = |s|, so only q needs forcing.
                q_res_d = (dvsr_q == '0) ? '1 : q_fix;
                r_res_d = r_fix;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            signed_q <= 1'b0;
            s_neg_q  <= 1'b0;
            t_neg_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            q_res_q  <= '0;
            r_res_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
            signed_q <= signed_d;
            s_neg_q  <= s_neg_d;
            t_neg_q  <= t_neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            q_res_q  <= q_res_d;
            r_res_q  <= r_res_d;
        end
    end

    assign bus.completed = done_q;
    assign bus.busy      = busy_q;
    assign bus.q         = q_res_q;
    assign bus.r         = r_res_q;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=32): directed corner cases plus
// randomized operands against an integer-arithmetic reference model.
module tb_seq_divider;
    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    seq_divider_if #(.WIDTH(32)) bus ();

    seq_divider #(.WIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V division semantics via 64-bit integer arithmetic.
    function automatic void ref_div(input bit sg, input logic [31:0] s, input logic [31:0] t,
                                    output logic [31:0] q, output logic [31:0] r);
        longint ss, tt, qq, rr;
        if (t == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = s;
        end else if (sg) begin
            ss = longint'($signed(s));
            tt = longint'($signed(t));
            qq = ss / tt;
            rr = ss % tt;
            q  = qq[31:0];
            r  = rr[31:0];
        end else begin
            q = s / t;
            r = s % t;
        end
    endfunction

    function automatic bit is_fast(input bit sg, input logic [31:0] s, input logic [31:0] t);
`ifdef DIV_FAST_PATH_EN
        return (t == 32'd0) || (t == 32'd1) || (sg && s == 32'h8000_0000 && t == 32'hFFFF_FFFF);
`else
        return 1'b0 & sg & (s == t);
`endif
    endfunction

    // Runs one division; immediate=1 drives enable in the current cycle,
    // poke=1 pulses enable with 1/1 while the divider is busy.
    task automatic do_op(input string name, input bit sg, input logic [31:0] s,
                         input logic [31:0] t, input bit immediate, input bit poke);
        logic [31:0] exp_q, exp_r;
        int          exp_lat, exp_busy, lat, busy_cnt;
        bit          got;
        ref_div(sg, s, t, exp_q, exp_r);
        exp_lat  = is_fast(sg, s, t) ? 1 : 33;
        exp_busy = is_fast(sg, s, t) ? 0 : 33;
        if (!immediate) @(negedge clk);
        bus.enable    = 1'b1;
        bus.is_signed = sg;
        bus.s         = s;
        bus.t         = t;
        @(posedge clk);
        #1;
        bus.enable    = 1'b0;
        bus.is_signed = 1'($urandom);
        bus.s         = $urandom;
        bus.t         = $urandom;
        lat = 0;
        busy_cnt = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            if (bus.busy) busy_cnt++;
            if (poke) begin
                bus.enable = (lat == 5 || lat == 20);
                bus.s      = 32'd1;
                bus.t      = 32'd1;
            end
            @(posedge clk);
            #1;
            lat++;
            if (bus.completed) got = 1'b1;
        end
        bus.enable = 1'b0;
        $display("op %s sg=%0d s=%08h t=%08h -> q=%08h r=%08h lat=%0d busy=%0d",
                 name, sg, s, t, bus.q, bus.r, lat, busy_cnt);
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
        end
        checks++;
        if (busy_cnt !== exp_busy) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, exp_busy);
        end
        checks++;
        if (bus.q !== exp_q) begin
            errors++;
            $display("FAIL %s q: got %08h expected %08h", name, bus.q, exp_q);
        end
        checks++;
        if (bus.r !== exp_r) begin
            errors++;
            $display("FAIL %s r: got %08h expected %08h", name, bus.r, exp_r);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.completed, bus.busy, bus.q, bus.r} !== 66'd0) begin
            errors++;
            $display("FAIL reset_outputs: got c=%b b=%b q=%08h r=%08h expected all zero",
                     bus.completed, bus.busy, bus.q, bus.r);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.completed !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got c=%b b=%b expected 0 0", bus.completed, bus.busy);
        end
    endtask

    task automatic test_unsigned_basic();
        do_op("udiv_100_7", 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (bus.completed !== 1'b0) begin
            errors++;
            $display("FAIL completed_pulse_width: got %b expected 0", bus.completed);
        end
        checks++;
        if (bus.q !== 32'd14 || bus.r !== 32'd2) begin
            errors++;
            $display("FAIL result_hold: got q=%08h r=%08h expected 0000000e 00000002", bus.q, bus.r);
        end
    endtask

    task automatic test_signed();
        do_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        do_op("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sdiv_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sdiv_by_one", 1'b1, 32'hFFFF_FF00, 32'd1, 1'b0, 1'b0);
    endtask

    task automatic test_div_zero();
        do_op("sdiv_5_0", 1'b1, 32'd5, 32'd0, 1'b0, 1'b0);
        do_op("udiv_dead_0", 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        do_op("sdiv_neg_0", 1'b1, 32'h8000_0003, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        do_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("udiv_ovf_ops", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_busy();
        do_op("udiv_poked", 1'b0, 32'd100, 32'd7, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        do_op("b2b_first", 1'b0, 32'd1000, 32'd33, 1'b0, 1'b0);
        do_op("b2b_second", 1'b1, 32'hFFFF_FC18, 32'd7, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        int late_done = 0;
        @(negedge clk);
        bus.enable    = 1'b1;
        bus.is_signed = 1'b0;
        bus.s         = 32'd100;
        bus.t         = 32'd7;
        @(posedge clk);
        #1;
        bus.enable = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.completed, bus.busy, bus.q, bus.r} !== 66'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got c=%b b=%b q=%08h r=%08h expected all zero",
                     bus.completed, bus.busy, bus.q, bus.r);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.completed) late_done++;
        end
        $display("op abandoned_100_7 completed_after_reset=%0d", late_done);
        checks++;
        if (late_done !== 0) begin
            errors++;
            $display("FAIL abandoned_no_completed: got %0d pulses expected 0", late_done);
        end
        do_op("after_reset_9_3", 1'b0, 32'd9, 32'd3, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] s, t;
        bit          sg;
        for (int i = 0; i < 16; i++) begin
            sg = 1'($urandom);
            s  = $urandom;
            case ($urandom_range(0, 5))
                0: t = 32'($urandom_range(1, 15));
                1: t = -32'($urandom_range(1, 15));
                2: t = 32'd0;
                3: t = s >> $urandom_range(1, 20);
                default: t = $urandom;
            endcase
            if (i == 7) begin
                s = 32'h8000_0000;
                t = 32'hFFFF_FFFF;
            end
            do_op($sformatf("rand%0d", i), sg, s, t, 1'($urandom), 1'b0);
        end
    endtask

    initial begin
        bus.enable    = 1'b0;
        bus.is_signed = 1'b0;
        bus.s         = '0;
        bus.t         = '0;
        rstn          = 1'b0;
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_div_zero();
        test_overflow();
        test_ignore_busy();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring divider serving the `div` handshake issued by the ALU: enable pulse in, single-cycle `completed` pulse out.
- Produces quotient and remainder together for RV32M div/divu/rem/remu, signed or unsigned.
- Fully defines the RISC-V corner cases, so the ALU may also forward divide-by-zero and overflow operands.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥2.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- enable  input  1  start request; sampled only in IDLE
- is_signed  input  1  1 = two's-complement (div/rem), 0 = unsigned (divu/remu); sampled with enable
- s  input  WIDTH  dividend; sampled with enable
- t  input  WIDTH  divisor; sampled with enable
- completed  output  1  one-cycle pulse; q/r valid in the same cycle
- busy  output  1  high from the accept edge until the edge that raises completed
- q  output  WIDTH  quotient, held until the next completion
- r  output  WIDTH  remainder, held until the next completion

Behaviour:
- Reset (rstn=0, asynchronous): state=IDLE, completed=0, busy=0, q=0, r=0, iteration counter=0. Reset mid-operation abandons it; no completed pulse follows.
- States:
  - IDLE: enable=1 at edge k accepts the request. Latch is_signed, sign(s), sign(t) and the magnitudes |s|, |t| (magnitudes only when is_signed; otherwise raw values). Clear the partial remainder. cnt=0, busy=1, go to ITER.
  - ITER: each edge performs one restoring step. Shift {rem, quot} left by 1, try rem − divisor; if non-negative, keep the difference and set quot LSB=1. cnt increments. The step at cnt=WIDTH−1 (edge k+WIDTH) moves to FIX.
  - FIX (edge k+WIDTH+1): apply signs. q is negated iff is_signed and sign(s)≠sign(t); r takes sign(s). Register q and r, set completed=1, busy=0, go to IDLE.
- Latency: completed is high in the cycle after edge k+WIDTH+1, i.e. 33 edges for WIDTH=32. Deasserted at the next edge.
- enable while busy: ignored; no queueing, no operand change.
- enable in the cycle completed=1: state is already IDLE, so it is accepted. Back-to-back throughput is one operation per WIDTH+2 cycles.
- Divide by zero (t=0), either signedness: q=all ones, r=s. Signed: the sign fix must not flip q. Force this result in FIX.
- Signed overflow (s=1<<(WIDTH−1), t=all ones, is_signed=1): q=s, r=0.
- Signed magnitude of the most negative value is 1<<(WIDTH−1) as an unsigned WIDTH-bit number; no extra width needed.
- Internal remainder is WIDTH+1 bits, so the trial subtraction borrow is the sign bit.
- Inputs need not be held after the accept edge.

Optional Feature:
- Macro: DIV_FAST_PATH_EN.
- Defined: at the accept edge, divide-by-zero, signed overflow, and t==1 bypass ITER. q/r are written and completed=1 at edge k+1 (1-edge latency); busy never rises.
- Not defined: every operation, including the corner cases, takes the fixed WIDTH+1-edge latency above.
- Results are identical either way.

Decomposition:
- Shared package (def.sv): typedef enum div_state_t {IDLE, ITER, FIX}; localparam DIV_LATENCY = WIDTH+1.
- One combinational sub-module, div_step: inputs rem, quot, divisor; outputs next rem and next quot for one restoring iteration.
- All sequencing stays in seq_divider.

Test Plan:
- Unsigned 100/7, enable at edge k → completed only in the cycle after edge k+33; q=14, r=2; busy high for exactly 33 cycles.
- Signed −7/2 (s=FFFFFFF9, t=2) → q=FFFFFFFD, r=FFFFFFFF. Signed 7/−2 → q=FFFFFFFD, r=1.
- Divide by zero: signed 5/0 → q=FFFFFFFF, r=5. Unsigned 0xDEADBEEF/0 → q=FFFFFFFF, r=DEADBEEF.
- Overflow: signed 80000000/FFFFFFFF → q=80000000, r=0. Same operands unsigned → q=0, r=80000000. With DIV_FAST_PATH_EN, signed case completes at edge k+1.
- Protocol:
  - enable pulses with 1/1 mid-operation → ignored; the original 100/7 result returned.
  - enable asserted during the completed cycle → accepted; second result after 33 more edges.
- Reset: rstn low at edge k+10 of an operation → all outputs 0 immediately (asynchronous); no completed pulse; a fresh 9/3 afterward → q=3, r=0.
